// File: rtl/proc_instr_sequencer.sv
// Run/Done initiator: a loadable 9-bit program store feeds DIN/Run one instruction at a time.
// Moore outputs with no added latency; waits on Done with a bounded timeout; loads accepted only when not busy.
module proc_instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock_i,
  input  logic          Resetn_i,
  input  logic          Start_i,
  input  logic          LdEn_i,
  input  logic [AW-1:0] LdAddr_i,
  input  logic [8:0]    LdData_i,
  input  logic          Done_i,
  output logic [8:0]    DIN_o,
  output logic          Run_o,
  output logic          Busy_o,
  output logic          Finished_o,
  output logic          Error_o,
  output logic [AW:0]   PC_o,
  output logic [7:0]    IssueCount_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALTED,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      icnt_q, icnt_d;
  logic [8:0]      store_q [DEPTH];

  logic [8:0]      word;
  logic [2:0]      op;
  logic            is_halt;
  logic            is_mvi;
  logic            at_last;
  logic            at_end;
  logic            quiescent;
  logic            ld_we;

  assign word      = store_q[pc_q[AW-1:0]];
  assign op        = word[8:6];
  assign is_halt   = op[2];
  assign is_mvi    = (op == 3'b001);
  assign at_last   = (pc_q == (AW+1)'(DEPTH - 1));
  assign at_end    = (pc_q == (AW+1)'(DEPTH));
  assign quiescent = (state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERR);
  assign ld_we     = LdEn_i && quiescent;

  // Program store is deliberately outside the reset domain so a reset keeps the program.
  always_ff @(posedge Clock_i) begin
    if (ld_we) begin
      store_q[LdAddr_i] <= LdData_i;
    end
  end

  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      icnt_q  <= icnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    icnt_d     = icnt_q;
    DIN_o      = 9'd0;
    Run_o      = 1'b0;
    Busy_o     = 1'b0;
    Finished_o = 1'b0;
    Error_o    = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALTED, S_ERR: begin
        Finished_o = (state_q == S_HALTED);
        Error_o    = (state_q == S_ERR);
        if (Start_i) begin
          state_d = S_ISSUE;
          pc_d    = '0;
          icnt_d  = '0;
        end
      end

      S_ISSUE: begin
        Busy_o = 1'b1;
        DIN_o  = word;
        if (is_halt) begin
          state_d = S_HALTED;
        end else if (is_mvi && at_last) begin
          // The immediate would fall off the end of the store: fault without issuing.
          state_d = S_ERR;
        end else begin
          Run_o = 1'b1;
          pc_d  = pc_q + (AW+1)'(1);
          cnt_d = '0;
          state_d = is_mvi ? S_IMM : S_WAIT;
        end
      end

      S_IMM: begin
        Busy_o  = 1'b1;
        DIN_o   = word;
        pc_d    = pc_q + (AW+1)'(1);
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        Busy_o = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        // First WAIT cycle may still see the previous instruction's Done.
        if (Done_i && (cnt_q != '0)) begin
          icnt_d  = icnt_q + 8'd1;
          state_d = at_end ? S_HALTED : S_ISSUE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = S_ERR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PC_o         = pc_q;
  assign IssueCount_o = icnt_q;

endmodule
